// File: rtl/sort_result_checker.sv
// sort_result_checker
// Watches the fetch PC for a halt (self-loop) or a cycle timeout, then reads a
// data-memory array through a debug read port and checks it against an
// ordering rule, producing a pass/fail verdict with error count and index.
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | program running; counting cycles and PC stability
// SCAN  | issuing one read per element
// DRAIN | last datum returning and being compared
// DONE  | verdict valid and held
module sort_result_checker #(
  parameter int                ADDR_W      = 32,
  parameter int                WORD_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h200,
  parameter int                NUM_ELEMS   = 10,
  parameter int                CHECK_MODE  = 2,
  parameter int                SIGNED_CMP  = 0,
  parameter int                HALT_STABLE = 8,
  parameter int                MAX_CYCLES  = 350,
  parameter int                CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [WORD_W-1:0] mem_rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  first_err_idx,
  output logic [CNT_W-1:0]  run_cycles
);

  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(WORD_W / 8);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NUM_ELEMS - 1);
  localparam logic [CNT_W-1:0]  HALT_TC  = CNT_W'(HALT_STABLE - 1);
  localparam logic [CNT_W-1:0]  TO_TC    = CNT_W'(MAX_CYCLES - 1);
  // A timeout beyond what the saturating cycle counter can represent never fires.
  localparam bit TO_EN = (MAX_CYCLES >= 1) && (longint'(MAX_CYCLES) < (longint'(1) << CNT_W));

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t             r_state, w_next;
  logic [ADDR_W-1:0]  r_last_pc, r_addr;
  logic [CNT_W-1:0]   r_stable, r_run, r_idx, r_cmp_idx, r_err, r_first;
  logic [WORD_W-1:0]  r_prev;
  logic               r_cmp_vld, r_timeout, r_pass;
  logic               w_halt, w_tmo, w_fail;
  logic [CNT_W-1:0]   w_err_next;
  logic [WORD_W-1:0]  w_expect;

  assign w_halt = (pc_in == r_last_pc) && (r_stable == HALT_TC);
  assign w_tmo  = TO_EN && (r_run == TO_TC);
  assign w_expect = WORD_W'(LAST_IDX - r_cmp_idx);

  // Judge the datum arriving this cycle against the selected ordering rule.
  always_comb begin
    w_fail = 1'b0;
    if (CHECK_MODE == 2) begin
      w_fail = (mem_rd_data != w_expect);
    end else if (r_cmp_idx != '0) begin
      if (SIGNED_CMP != 0) begin
        w_fail = (CHECK_MODE == 0) ? ($signed(mem_rd_data) > $signed(r_prev))
                                   : ($signed(mem_rd_data) < $signed(r_prev));
      end else begin
        w_fail = (CHECK_MODE == 0) ? (mem_rd_data > r_prev) : (mem_rd_data < r_prev);
      end
    end
    w_fail = w_fail && r_cmp_vld;
    w_err_next = (w_fail && (r_err != '1)) ? r_err + 1'b1 : r_err;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state selection; halt takes priority over timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_RUN;
      S_RUN:          if (w_halt || w_tmo) w_next = S_SCAN;
      S_SCAN:         if (r_idx == LAST_IDX) w_next = S_DRAIN;
      S_DRAIN:        w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end

  // State-decoded outputs; the read strobe drops in the reset cycle itself.
  always_comb begin
    mem_rd_en   = (r_state == S_SCAN) && !rst;
    busy        = (r_state == S_RUN) || (r_state == S_SCAN);
    done        = (r_state == S_DONE);
    mem_rd_addr = r_addr;
  end

  // Counters, halt detection, scan address and compare pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_pc <= '0;
      r_addr    <= '0;
      r_stable  <= '0;
      r_run     <= '0;
      r_idx     <= '0;
      r_cmp_idx <= '0;
      r_err     <= '0;
      r_first   <= '1;
      r_prev    <= '0;
      r_cmp_vld <= 1'b0;
      r_timeout <= 1'b0;
      r_pass    <= 1'b0;
    end else begin
      r_cmp_vld <= (r_state == S_SCAN);
      r_cmp_idx <= r_idx;
      if (r_cmp_vld) begin
        r_prev <= mem_rd_data;
        r_err  <= w_err_next;
        if (w_fail && (r_err == '0)) r_first <= r_cmp_idx;
      end
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_last_pc <= pc_in;
            r_stable  <= '0;
            r_run     <= '0;
            r_err     <= '0;
            r_first   <= '1;
            r_timeout <= 1'b0;
            r_pass    <= 1'b0;
            r_idx     <= '0;
            r_addr    <= BASE_ADDR;
          end
        end
        S_RUN: begin
          if (r_run != '1) r_run <= r_run + 1'b1;
          if (pc_in == r_last_pc) begin
            r_stable <= r_stable + 1'b1;
          end else begin
            r_stable  <= '0;
            r_last_pc <= pc_in;
          end
          if (w_tmo && !w_halt) r_timeout <= 1'b1;
          r_idx  <= '0;
          r_addr <= BASE_ADDR;
        end
        S_SCAN: begin
          if (r_idx != LAST_IDX) begin
            r_idx  <= r_idx + 1'b1;
            r_addr <= r_addr + STEP;
          end
        end
        S_DRAIN: r_pass <= (w_err_next == '0) && !r_timeout;
        default: ;
      endcase
    end
  end

  assign pass          = r_pass;
  assign timeout       = r_timeout;
  assign err_count     = r_err;
  assign first_err_idx = r_first;
  assign run_cycles    = r_run;

endmodule

// File: tb/tb_sort_result_checker.sv
// Bench for sort_result_checker: four instances (mode 2 N=10, mode 1 signed
// and unsigned N=5, mode 2 N=1) share clk/rst/start/pc and own read ports.
// Expectations come from a trace-level model computed before each run.
module tb_sort_result_checker;
  localparam int TRL = 400;
  localparam int HS  = 8;
  localparam int MAXC = 350;

  logic clk, rst, start;
  logic [31:0] pc_in;
  logic a_en, s_en, u_en, o_en;
  logic [31:0] a_addr, s_addr, u_addr, o_addr;
  logic [31:0] a_rd, s_rd, u_rd, o_rd;
  logic a_busy, a_done, a_pass, a_to, s_busy, s_done, s_pass, s_to;
  logic u_busy, u_done, u_pass, u_to, o_busy, o_done, o_pass, o_to;
  logic [15:0] a_err, a_first, a_run, s_err, s_first, s_run;
  logic [15:0] u_err, u_first, u_run, o_err, o_first, o_run;

  logic [31:0] mem_a [10];
  logic [31:0] mem_b [10];
  logic [31:0] tr [TRL];

  int n_cmp = 0, n_bad = 0;
  int t_rel = -1, rst_at = -1, chk_mode = 0, done_t_a = -1;
  int m_kx, ea_err, ea_first, es_err, es_first, eu_err, eu_first, eo_err, eo_first;
  bit m_to;

  sort_result_checker u_a (.clk(clk), .rst(rst), .start(start), .pc_in(pc_in),
    .mem_rd_en(a_en), .mem_rd_addr(a_addr), .mem_rd_data(a_rd), .busy(a_busy), .done(a_done),
    .pass(a_pass), .timeout(a_to), .err_count(a_err), .first_err_idx(a_first), .run_cycles(a_run));
  sort_result_checker #(.NUM_ELEMS(5), .CHECK_MODE(1), .SIGNED_CMP(1)) u_s (.clk(clk), .rst(rst),
    .start(start), .pc_in(pc_in), .mem_rd_en(s_en), .mem_rd_addr(s_addr), .mem_rd_data(s_rd),
    .busy(s_busy), .done(s_done), .pass(s_pass), .timeout(s_to), .err_count(s_err),
    .first_err_idx(s_first), .run_cycles(s_run));
  sort_result_checker #(.NUM_ELEMS(5), .CHECK_MODE(1), .SIGNED_CMP(0)) u_u (.clk(clk), .rst(rst),
    .start(start), .pc_in(pc_in), .mem_rd_en(u_en), .mem_rd_addr(u_addr), .mem_rd_data(u_rd),
    .busy(u_busy), .done(u_done), .pass(u_pass), .timeout(u_to), .err_count(u_err),
    .first_err_idx(u_first), .run_cycles(u_run));
  sort_result_checker #(.BASE_ADDR(32'h224), .NUM_ELEMS(1)) u_o (.clk(clk), .rst(rst),
    .start(start), .pc_in(pc_in), .mem_rd_en(o_en), .mem_rd_addr(o_addr), .mem_rd_data(o_rd),
    .busy(o_busy), .done(o_done), .pass(o_pass), .timeout(o_to), .err_count(o_err),
    .first_err_idx(o_first), .run_cycles(o_run));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rd_a(input logic [31:0] ad);
    logic [31:0] off;
    off = ad - 32'h200;
    if (off[1:0] == 2'b00 && off < 32'd40) return mem_a[off[5:2]];
    return 32'hBAD0BAD0;
  endfunction

  function automatic logic [31:0] rd_b(input logic [31:0] ad);
    logic [31:0] off;
    off = ad - 32'h200;
    if (off[1:0] == 2'b00 && off < 32'd20) return mem_b[off[5:2]];
    return 32'hBAD0BAD0;
  endfunction

  // Data memories: one-cycle read latency.
  always @(posedge clk) begin
    if (a_en) a_rd <= rd_a(a_addr);
    if (s_en) s_rd <= rd_b(s_addr);
    if (u_en) u_rd <= rd_b(u_addr);
    if (o_en) o_rd <= rd_a(o_addr);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0d got=%0h want=%0h", nm, t_rel, act, exp);
    end
  endtask

  // Halt = first RUN cycle k whose PC matches the previous HS PCs (start sample included).
  task automatic model_exit();
    bit found, eq;
    found = 0; m_to = 0; m_kx = MAXC - 1;
    for (int k = 0; k < MAXC && !found; k++) begin
      eq = (k + 1 >= HS);
      for (int j = 1; j <= HS; j++)
        if (eq && tr[k+1-j] != tr[k+1]) eq = 0;
      if (eq) begin m_kx = k; found = 1; end
    end
    if (!found) m_to = 1;
  endtask

  task automatic model_verdict(input logic [31:0] w [10], input int off, input int n,
                               input int mode, input bit sgn, output int err, output int first);
    logic [31:0] cur, prv;
    bit bad;
    err = 0; first = 32'hFFFF;
    for (int i = 0; i < n; i++) begin
      cur = w[off+i];
      bad = 0;
      if (mode == 2) bad = (cur != 32'(n - 1 - i));
      else if (i > 0) begin
        prv = w[off+i-1];
        if (mode == 0) bad = sgn ? ($signed(cur) > $signed(prv)) : (cur > prv);
        else           bad = sgn ? ($signed(cur) < $signed(prv)) : (cur < prv);
      end
      if (bad) begin
        if (err == 0) first = i;
        err++;
      end
    end
  endtask

  task automatic chk_inst(input string nm, input int n, input logic [31:0] base,
      input int ex_err, input int ex_first, input logic bz, input logic dn, input logic en,
      input logic [31:0] ad, input logic ps, input logic to, input logic [15:0] ec,
      input logic [15:0] fi, input logic [15:0] rc);
    int t;
    t = t_rel;
    if (t <= m_kx) begin
      chk({nm, ".run.busy"}, bz, 1); chk({nm, ".run.done"}, dn, 0); chk({nm, ".run.en"}, en, 0);
      chk({nm, ".run.cycles"}, rc, t); chk({nm, ".run.err"}, ec, 0);
      chk({nm, ".run.first"}, fi, 16'hFFFF); chk({nm, ".run.to"}, to, 0); chk({nm, ".run.pass"}, ps, 0);
    end else if (t <= m_kx + n) begin
      chk({nm, ".scan.busy"}, bz, 1); chk({nm, ".scan.done"}, dn, 0); chk({nm, ".scan.en"}, en, 1);
      chk({nm, ".scan.addr"}, ad, base + 32'(4 * (t - m_kx - 1)));
      chk({nm, ".scan.cycles"}, rc, m_kx + 1); chk({nm, ".scan.to"}, to, m_to);
    end else if (t == m_kx + n + 1) begin
      chk({nm, ".drain.busy"}, bz, 0); chk({nm, ".drain.done"}, dn, 0); chk({nm, ".drain.en"}, en, 0);
    end else begin
      chk({nm, ".done.busy"}, bz, 0); chk({nm, ".done.done"}, dn, 1); chk({nm, ".done.en"}, en, 0);
      chk({nm, ".done.pass"}, ps, (ex_err == 0) && !m_to); chk({nm, ".done.to"}, to, m_to);
      chk({nm, ".done.err"}, ec, ex_err); chk({nm, ".done.first"}, fi, ex_first);
      chk({nm, ".done.cycles"}, rc, m_kx + 1);
    end
  endtask

  task automatic chk_rst(input string nm, input logic bz, input logic dn, input logic en,
      input logic [31:0] ad, input logic ps, input logic to, input logic [15:0] ec,
      input logic [15:0] fi, input logic [15:0] rc);
    chk({nm, ".rst.busy"}, bz, 0); chk({nm, ".rst.done"}, dn, 0); chk({nm, ".rst.en"}, en, 0);
    chk({nm, ".rst.addr"}, ad, 0); chk({nm, ".rst.pass"}, ps, 0); chk({nm, ".rst.to"}, to, 0);
    chk({nm, ".rst.err"}, ec, 0); chk({nm, ".rst.first"}, fi, 16'hFFFF); chk({nm, ".rst.cycles"}, rc, 0);
  endtask

  // Compare process: every cycle of a run, all instances against the model.
  always @(negedge clk) begin
    if (chk_mode == 2 || (chk_mode == 1 && rst_at >= 0 && t_rel > rst_at)) begin
      chk_rst("a", a_busy, a_done, a_en, a_addr, a_pass, a_to, a_err, a_first, a_run);
      chk_rst("s", s_busy, s_done, s_en, s_addr, s_pass, s_to, s_err, s_first, s_run);
      chk_rst("u", u_busy, u_done, u_en, u_addr, u_pass, u_to, u_err, u_first, u_run);
      chk_rst("o", o_busy, o_done, o_en, o_addr, o_pass, o_to, o_err, o_first, o_run);
    end else if (chk_mode == 1 && t_rel >= 0 && (rst_at < 0 || t_rel < rst_at)) begin
      chk_inst("a", 10, 32'h200, ea_err, ea_first, a_busy, a_done, a_en, a_addr, a_pass, a_to, a_err, a_first, a_run);
      chk_inst("s", 5, 32'h200, es_err, es_first, s_busy, s_done, s_en, s_addr, s_pass, s_to, s_err, s_first, s_run);
      chk_inst("u", 5, 32'h200, eu_err, eu_first, u_busy, u_done, u_en, u_addr, u_pass, u_to, u_err, u_first, u_run);
      chk_inst("o", 1, 32'h224, eo_err, eo_first, o_busy, o_done, o_en, o_addr, o_pass, o_to, o_err, o_first, o_run);
      if (a_done && done_t_a < 0) done_t_a = t_rel;
    end
  end

  task automatic gen_trace(input int loop_at, input int stall_at, input int stall_len);
    logic [31:0] p;
    tr[0] = 32'h0;
    p = 32'h1000;
    for (int k = 0; k < TRL - 1; k++) begin
      if (loop_at >= 0 && k >= loop_at) tr[k+1] = 32'h0A0;
      else if (stall_at >= 0 && k > stall_at && k < stall_at + stall_len) tr[k+1] = tr[k];
      else begin
        p = p + 32'(4 * (1 + $urandom_range(0, 3)));
        tr[k+1] = p;
      end
    end
  endtask

  task automatic set_sorted_a();
    for (int i = 0; i < 10; i++) mem_a[i] = 32'(9 - i);
  endtask

  // One run: start, drive the trace, optional reset / extra starts relative to the halt cycle.
  task automatic run(input int rst_off, input int sb_run, input int sb_scan_off);
    int end_t, rst_t, sb2;
    model_exit();
    model_verdict(mem_a, 0, 10, 2, 0, ea_err, ea_first);
    model_verdict(mem_b, 0, 5, 1, 1, es_err, es_first);
    model_verdict(mem_b, 0, 5, 1, 0, eu_err, eu_first);
    model_verdict(mem_a, 9, 1, 2, 0, eo_err, eo_first);
    rst_t = (rst_off >= 0) ? m_kx + rst_off : -1;
    sb2   = (sb_scan_off >= 0) ? m_kx + sb_scan_off : -1;
    end_t = (rst_t >= 0) ? rst_t + 3 : m_kx + 15;
    @(posedge clk); #1;
    start = 1'b1; pc_in = tr[0]; t_rel = -1; rst_at = rst_t; done_t_a = -1; chk_mode = 1;
    for (int t = 0; t <= end_t; t++) begin
      @(posedge clk); #1;
      start = (t == sb_run) || (t == sb2);
      rst   = (t == rst_t);
      pc_in = tr[t+1];
      t_rel = t;
    end
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b0; chk_mode = 0;
  endtask

  initial begin
    int v;
    rst = 1'b1; start = 1'b0; pc_in = '0;
    set_sorted_a();
    mem_b[0] = -32'sd3; mem_b[1] = -32'sd1; mem_b[2] = 32'd0; mem_b[3] = 32'd0; mem_b[4] = 32'd7;
    for (int i = 5; i < 10; i++) mem_b[i] = '0;
    repeat (2) @(posedge clk);
    #1 chk_mode = 2;
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_mode = 0;

    // Sorted 9..0, halt loop from cycle 120.
    gen_trace(120, -1, 0);
    run(-1, -1, -1);
    chk("t1.done_cycle", done_t_a, 140);
    chk("t1.pass", a_pass, 1); chk("t1.err", a_err, 0); chk("t1.first", a_first, 16'hFFFF);
    chk("t1.timeout", a_to, 0);
    chk("t1.signed.pass", s_pass, 1);
    chk("t1.unsigned.err", u_err, 1); chk("t1.unsigned.first", u_first, 2);
    chk("t1.one.pass", o_pass, 1);

    // Word at 0x20C corrupted to 5 (restarted from DONE).
    mem_a[3] = 32'd5;
    run(-1, -1, -1);
    chk("t2.pass", a_pass, 0); chk("t2.err", a_err, 1); chk("t2.first", a_first, 3);

    // PC never settles: timeout, scan still runs, verdict fails.
    set_sorted_a();
    gen_trace(-1, -1, 0);
    run(-1, -1, -1);
    chk("t3.timeout", a_to, 1); chk("t3.cycles", a_run, 350); chk("t3.pass", a_pass, 0);
    chk("t3.done_cycle", done_t_a, 361);

    // Halt and timeout in the same cycle: halt wins.
    gen_trace(341, -1, 0);
    run(-1, -1, -1);
    chk("t4.timeout", a_to, 0); chk("t4.cycles", a_run, 350); chk("t4.pass", a_pass, 1);

    // Short stall does not count as halt.
    gen_trace(100, 50, 6);
    run(-1, -1, -1);
    chk("t5.cycles", a_run, 109);

    // start pulses while busy are ignored.
    gen_trace(30, -1, 0);
    run(-1, 5, 2);
    chk("t6.cycles", a_run, 39); chk("t6.done_cycle", done_t_a, 50);

    // Reset on the third scan read, then a clean rerun.
    gen_trace(20, -1, 0);
    run(3, -1, -1);
    chk("t7.busy", a_busy, 0); chk("t7.en", a_en, 0); chk("t7.first", a_first, 16'hFFFF);
    run(-1, -1, -1);
    chk("t8.pass", a_pass, 1); chk("t8.cycles", a_run, 29);

    // Randomized runs.
    for (int r = 0; r < 8; r++) begin
      set_sorted_a();
      for (int i = 0; i < 10; i++)
        if ($urandom_range(0, 4) == 0) mem_a[i] = 32'($urandom_range(0, 12));
      v = -6;
      for (int i = 0; i < 5; i++) begin
        if (r[0]) v = v + int'($urandom_range(0, 3));
        else      v = int'($urandom_range(0, 12)) - 6;
        mem_b[i] = 32'(v);
      end
      gen_trace(int'($urandom_range(0, 360)), int'($urandom_range(0, 100)), int'($urandom_range(2, 8)));
      run(-1, (r == 3) ? 4 : -1, (r == 5) ? 1 : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sort_result_checker.md
Name: sort_result_checker

Overview:
- Synthesizable self-check block for pipelined RISC-V program runs. It replaces the fixed-delay, print-and-eyeball check with a hardware pass/fail verdict.
- Watches the fetch PC to detect program halt (self-loop) or a cycle timeout.
- Then scans a parametrised data-memory region through a dedicated read port and checks it against a selectable ordering rule.
- Sits beside the processor in the bench or an FPGA wrapper, reading the data memory's debug read port.

Parameters:
- ADDR_W, 32, width of PC and memory byte address.
- WORD_W, 32, width of one array element; must be a multiple of 8.
- BASE_ADDR, 32'h200, byte address of element 0.
- NUM_ELEMS, 10, element count N (1..65535).
- CHECK_MODE, 2, 0 = non-increasing, 1 = non-decreasing, 2 = exact sequence N-1 down to 0.
- SIGNED_CMP, 0, 1 = compare elements as two's complement in modes 0/1.
- HALT_STABLE, 8, consecutive cycles of unchanged PC that count as halt.
- MAX_CYCLES, 350, run-cycle timeout.
- CNT_W, 16, width of all counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse to begin monitoring; sample it the same cycle CPU reset is released.
- pc_in  in  ADDR_W  fetch-stage PC of the processor.
- mem_rd_en  out  1  read strobe to data memory.
- mem_rd_addr  out  ADDR_W  byte address = BASE_ADDR + i*(WORD_W/8).
- mem_rd_data  in  WORD_W  read data, valid exactly 1 cycle after mem_rd_en; little-endian word.
- busy  out  1  high in RUN and SCAN.
- done  out  1  verdict valid; held until the next accepted start or rst.
- pass  out  1  1 = zero errors and no timeout; meaningful only while done.
- timeout  out  1  MAX_CYCLES reached before halt.
- err_count  out  CNT_W  number of failing elements.
- first_err_idx  out  CNT_W  index of first failing element; all-ones if none.
- run_cycles  out  CNT_W  cycles spent in RUN, saturating.

Behaviour:
- Reset values: all outputs 0, except first_err_idx = all-ones. State is IDLE.
- States: IDLE, RUN, SCAN, DRAIN, DONE.
- IDLE or DONE + start: clear all counters and flags, capture pc_in as last_pc, go to RUN.
- start in RUN, SCAN or DRAIN is ignored.
- RUN, every cycle:
  - run_cycles increments.
  - If pc_in equals last_pc, stable_cnt increments; otherwise stable_cnt = 0 and last_pc = pc_in.
  - When stable_cnt reaches HALT_STABLE-1 with the PC still equal, go to SCAN.
  - Otherwise, when run_cycles reaches MAX_CYCLES-1, set timeout and go to SCAN.
  - If both conditions occur in the same cycle, halt wins and timeout stays 0.
- SCAN:
  - Issue mem_rd_en for i = 0..N-1 in N consecutive cycles, with mem_rd_addr incrementing by WORD_W/8.
  - After issuing i = N-1, go to DRAIN for one cycle while the last datum returns.
  - The address computation wraps modulo 2^ADDR_W, with no error.
- Compare pipeline: the datum for index i is checked in the cycle it arrives.
  - Mode 2: element i fails if the word is not N-1-i.
  - Modes 0/1: element 0 never fails. Element i>0 fails if it breaks the ordering against element i-1, using the previous datum held in a register.
  - Equal adjacent values pass in modes 0/1.
  - Each failure increments err_count, saturating at all-ones. The first failure loads first_err_idx.
- DRAIN: the last compare completes, then go to DONE.
  - done rises the cycle after the last datum is compared.
  - pass = (err_count == 0) && !timeout, computed from the final count.
- Total latency from the halt decision to done = N+2 cycles.
- DONE: outputs hold and mem_rd_en = 0.
- N = 1: a single read; mode 2 expects 0.
- rst in any state, including mid-SCAN: return to IDLE immediately, restore reset values, deassert mem_rd_en the same cycle.
- run_cycles saturates at all-ones. If MAX_CYCLES exceeds the CNT_W range, timeout never fires.

Test Plan:
- Memory model holds 9,8,...,0 at 0x200 in mode 2; PC loops at 0x0A0 from cycle 120. Required: done at cycle 120+8+12, pass=1, err_count=0, first_err_idx=FFFF, timeout=0.
- Same, but the word at 0x20C is 5 instead of 6. Required: pass=0, err_count=1, first_err_idx=3.
- PC keeps changing for 400 cycles. Required: timeout=1 at run_cycles=350, scan still runs, pass=0 even with a correct array.
- Mode 1, SIGNED_CMP=1, array -3,-1,0,0,7. Required: pass=1. Same array with SIGNED_CMP=0: err_count=1, first_err_idx=2.
- PC stalls for 5 cycles (pipeline stall < HALT_STABLE), then continues. Required: no transition to SCAN.
- rst asserted at the third SCAN read, then start reissued. Required: mem_rd_en low the next cycle, outputs at reset values, second run gives the correct verdict.
- start pulsed while busy. Required: it has no effect and run_cycles is not cleared.
